// File: rtl/game_sequencer.sv
// game_sequencer: chooses the next opcode for the plate (housekeeping queue, gravity, player)
// and runs the issue/complete/acknowledge handshake. Define GAME_SEQ_LEVEL_EN for level progression.
package game_sequencer_pkg;
  typedef enum logic [2:0] {
    eNop, eMoveLeft, eMoveRight, eMoveDown, eRotate, eNew, eCommit, eCheck
  } opcode_e;
endpackage

module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned gravity_period_p  = 50000000,
  parameter int unsigned period_step_p     = 4000000,
  parameter int unsigned min_period_p      = 5000000,
  parameter int unsigned lines_per_level_p = 10
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  opcode_e    usr_opcode_i,
  input  logic       usr_v_i,
  output logic       usr_yumi_o,
  output opcode_e    opcode_o,
  output logic       opcode_v_o,
  input  logic       ready_i,
  input  logic       done_i,
  output logic       yumi_o,
  input  logic       landed_i,
  input  logic [2:0] line_elimination_i,
  input  logic       line_elimination_v_i,
  input  logic       lose_i,
  output logic       game_over_o,
  output logic [3:0] level_o
);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, ACK, OVER} state_e;

  state_e      state_r;
  opcode_e     q_r [3];
  logic [1:0]  q_cnt_r;
  logic [31:0] grav_cnt_r;
  logic        pending_r;
  logic        lose_r;
  logic [31:0] period;
  logic        running;
  logic        q_empty;
  logic        tick;
  logic        pick_queue;
  logic        pick_grav;
  logic        pick_usr;

  assign running    = (state_r != IDLE) && (state_r != OVER);
  assign q_empty    = (q_cnt_r == '0);
  // >= rather than == so a period shortened by a level change cannot be overrun
  assign tick       = running && (grav_cnt_r >= period - 32'd1);
  assign pick_queue = (state_r == SELECT) && !q_empty;
  assign pick_grav  = (state_r == SELECT) && q_empty && pending_r;
  assign pick_usr   = (state_r == SELECT) && q_empty && !pending_r && usr_v_i;
  assign usr_yumi_o = pick_usr;

`ifdef GAME_SEQ_LEVEL_EN
  logic        game_start;
  logic [15:0] line_cnt_r;
  logic [15:0] line_sum;
  logic [31:0] reduction;
  logic [3:0]  level_r;

  assign game_start = ((state_r == IDLE) || (state_r == OVER)) && start_i;
  assign line_sum   = line_cnt_r + (line_elimination_v_i ? 16'(line_elimination_i) : 16'd0);
  assign reduction  = 32'(level_r) * period_step_p;
  assign level_o    = level_r;

  always_comb begin
    period = min_period_p;
    if ((gravity_period_p > reduction) && (gravity_period_p - reduction > min_period_p))
      period = gravity_period_p - reduction;
  end

  // A large clear leaves a remainder >= lines_per_level_p, which drains one level per cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      line_cnt_r <= '0;
      level_r    <= '0;
    end else if (game_start) begin
      line_cnt_r <= '0;
      level_r    <= '0;
    end else if (running) begin
      if (line_sum >= 16'(lines_per_level_p)) begin
        line_cnt_r <= line_sum - 16'(lines_per_level_p);
        if (level_r != 4'hF) level_r <= level_r + 4'd1;
      end else begin
        line_cnt_r <= line_sum;
      end
    end
  end
`else
  logic unused_lines;
  assign unused_lines = ^{line_elimination_i, line_elimination_v_i};
  assign period       = gravity_period_p;
  assign level_o      = '0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      q_r         <= '{default: eNop};
      q_cnt_r     <= '0;
      grav_cnt_r  <= '0;
      pending_r   <= 1'b0;
      lose_r      <= 1'b0;
      opcode_o    <= eNop;
      opcode_v_o  <= 1'b0;
      yumi_o      <= 1'b0;
      game_over_o <= 1'b0;
    end else begin
      if (running) begin
        if (tick) begin
          grav_cnt_r <= '0;
          if (q_empty) pending_r <= 1'b1;
        end else begin
          grav_cnt_r <= grav_cnt_r + 32'd1;
        end
      end
      // Assignments below come later so a selection overrides a same-cycle tick
      case (state_r)
        IDLE, OVER: begin
          if (start_i) begin
            q_r[0]      <= eNew;
            q_cnt_r     <= 2'd1;
            grav_cnt_r  <= '0;
            pending_r   <= 1'b0;
            lose_r      <= 1'b0;
            game_over_o <= 1'b0;
            state_r     <= SELECT;
          end
        end
        SELECT: begin
          if (pick_queue) begin
            opcode_o <= q_r[0];
            q_r[0]   <= q_r[1];
            q_r[1]   <= q_r[2];
            q_r[2]   <= eNop;
            q_cnt_r  <= q_cnt_r - 2'd1;
          end else if (pick_grav) begin
            opcode_o  <= eMoveDown;
            pending_r <= 1'b0;
          end else if (pick_usr) begin
            opcode_o <= usr_opcode_i;
            if (usr_opcode_i == eMoveDown) begin
              grav_cnt_r <= '0;
              pending_r  <= 1'b0;
            end
          end
          if (pick_queue || pick_grav || pick_usr) begin
            opcode_v_o <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ready_i) begin
            opcode_v_o <= 1'b0;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          if (done_i) begin
            yumi_o  <= 1'b1;
            lose_r  <= lose_i;
            state_r <= ACK;
            if ((opcode_o == eMoveDown) && landed_i) begin
              q_r     <= '{eCommit, eCheck, eNew};
              q_cnt_r <= 2'd3;
            end
          end
        end
        ACK: begin
          yumi_o <= 1'b0;
          if (lose_r) begin
            state_r     <= OVER;
            game_over_o <= 1'b1;
            q_r         <= '{default: eNop};
            q_cnt_r     <= '0;
          end else begin
            state_r <= SELECT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: a transaction-level game model predicts opcodes,
// acknowledges, player consumption and game-over events; a monitor scores the DUT outputs.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  localparam int GP   = 8;
  localparam int STEP = 2;
  localparam int MINP = 4;
  localparam int LPL  = 2;

  localparam int PH_SEL   = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_ACK   = 3;

  typedef struct packed {
    opcode_e    op;
    logic [3:0] lvl;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       start_i;
  opcode_e    usr_opcode_i;
  logic       usr_v_i;
  logic       usr_yumi_o;
  opcode_e    opcode_o;
  logic       opcode_v_o;
  logic       ready_i;
  logic       done_i;
  logic       yumi_o;
  logic       landed_i;
  logic [2:0] line_elimination_i;
  logic       line_elimination_v_i;
  logic       lose_i;
  logic       game_over_o;
  logic [3:0] level_o;

  game_sequencer #(
    .gravity_period_p (GP),
    .period_step_p    (STEP),
    .min_period_p     (MINP),
    .lines_per_level_p(LPL)
  ) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .start_i             (start_i),
    .usr_opcode_i        (usr_opcode_i),
    .usr_v_i             (usr_v_i),
    .usr_yumi_o          (usr_yumi_o),
    .opcode_o            (opcode_o),
    .opcode_v_o          (opcode_v_o),
    .ready_i             (ready_i),
    .done_i              (done_i),
    .yumi_o              (yumi_o),
    .landed_i            (landed_i),
    .line_elimination_i  (line_elimination_i),
    .line_elimination_v_i(line_elimination_v_i),
    .lose_i              (lose_i),
    .game_over_o         (game_over_o),
    .level_o             (level_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard queues filled by the model
  exp_t op_q[$];
  int   ack_q[$];
  int   uy_q[$];
  int   go_q[$];

  // Game model state
  int      cyc = 0;
  bit      m_run = 0;
  bit      m_over = 0;
  bit      m_lose = 0;
  int      ph = PH_SEL;
  opcode_e mq[$];
  opcode_e cur = eNop;
  int      base = 0;
  bit      pend = 0;
  int      m_lines = 0;
  bit      consumed = 0;
  int      rdy_hold = 0;

  function automatic int model_level();
`ifdef GAME_SEQ_LEVEL_EN
    return (m_lines / LPL > 15) ? 15 : m_lines / LPL;
`else
    return 0;
`endif
  endfunction

  function automatic int model_period();
    int p;
    p = GP - model_level() * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  // Advance the game by one clock edge using the inputs the DUT sampled on it
  task automatic model_step();
    bit   tick, qe, gsel;
    exp_t e;
    cyc++;
    consumed = 0;
    if (!m_run) begin
      if (start_i) begin
        m_run = 1; ph = PH_SEL; base = cyc; pend = 0; m_lines = 0; m_lose = 0;
        mq.delete(); mq.push_back(eNew);
        if (m_over) begin m_over = 0; go_q.push_back(cyc); end
      end
      return;
    end
    qe   = (mq.size() == 0);
    tick = (cyc - base) >= model_period();
    if (tick) base = cyc;
    gsel = 0;
    case (ph)
      PH_SEL: begin
        if (!qe) begin
          cur = mq.pop_front(); ph = PH_ISSUE;
        end else if (pend) begin
          cur = eMoveDown; pend = 0; gsel = 1; ph = PH_ISSUE;
        end else if (usr_v_i) begin
          cur = usr_opcode_i; uy_q.push_back(cyc); consumed = 1; ph = PH_ISSUE;
          if (cur == eMoveDown) begin base = cyc; gsel = 1; end
        end
        if (ph == PH_ISSUE) begin
          e.op = cur; e.lvl = 4'(model_level()); op_q.push_back(e);
        end
      end
      PH_ISSUE: if (ready_i) ph = PH_WAIT;
      PH_WAIT: if (done_i) begin
        ack_q.push_back(cyc); ph = PH_ACK; m_lose = lose_i;
        if (cur == eMoveDown && landed_i) begin
          mq.delete(); mq.push_back(eCommit); mq.push_back(eCheck); mq.push_back(eNew);
        end
      end
      default: begin
        if (m_lose) begin
          m_run = 0; m_over = 1; mq.delete(); go_q.push_back(cyc);
        end else ph = PH_SEL;
      end
    endcase
    if (tick && qe && !gsel) pend = 1;
    if (line_elimination_v_i) m_lines += int'(line_elimination_i);
  endtask

  task automatic drive_inputs(bit allow_start);
    start_i = allow_start && ($urandom_range(0, 7) == 0);
    if (rdy_hold > 0) begin ready_i = 1'b0; rdy_hold--; end
    else if ($urandom_range(0, 9) == 0) begin ready_i = 1'b0; rdy_hold = 4; end
    else ready_i = ($urandom_range(0, 4) != 0);
    done_i   = 1'b0;
    landed_i = 1'($urandom_range(0, 1));
    lose_i   = 1'($urandom_range(0, 1));
    if (m_run && ph == PH_WAIT && $urandom_range(0, 2) != 0) begin
      done_i   = 1'b1;
      landed_i = ($urandom_range(0, 3) == 0);
      lose_i   = ($urandom_range(0, 19) == 0);
    end
    line_elimination_i = 3'($urandom_range(0, 7));
`ifdef GAME_SEQ_LEVEL_EN
    line_elimination_v_i = done_i && (cur == eCheck) && ($urandom_range(0, 1) == 1);
    if (line_elimination_v_i) line_elimination_i = 3'd1;
`else
    line_elimination_v_i = 1'($urandom_range(0, 1));
`endif
    if (!(usr_v_i && !consumed)) begin
      usr_v_i      = ($urandom_range(0, 2) == 0);
      usr_opcode_i = opcode_e'(3'($urandom_range(1, 4)));
    end
  endtask

  task automatic cycle_step(bit allow_start);
    @(posedge clk_i);
    model_step();
    #1;
    drive_inputs(allow_start);
  endtask

  // Monitor: scores DUT outputs against the model's expectations
  initial begin : monitor
    logic    pv, pacc, pgo;
    opcode_e pop;
    int      uy_seen;
    exp_t    e;
    pv = 0; pacc = 0; pgo = 0; pop = eNop; uy_seen = -1;
    forever begin
      @(negedge clk_i);
      if (opcode_v_o && pv && !pacc) check("opcode_stable", opcode_o, pop);
      if (opcode_v_o && ready_i) begin
        if (op_q.size() == 0) check("opcode_unexpected", opcode_v_o, 0);
        else begin
          e = op_q.pop_front();
          check("opcode", opcode_o, e.op);
          check("level", level_o, e.lvl);
        end
      end
      pv = opcode_v_o; pacc = opcode_v_o && ready_i; pop = opcode_o;
      if (yumi_o) begin
        if (ack_q.size() == 0) check("yumi_unexpected", yumi_o, 0);
        else check("yumi_cycle", cyc, ack_q.pop_front());
      end
      if (uy_seen >= 0) begin
        if (uy_q.size() == 0) check("usr_yumi_unexpected", uy_seen, -1);
        else check("usr_yumi_cycle", uy_seen, uy_q.pop_front());
        uy_seen = -1;
      end
      if (usr_yumi_o) uy_seen = cyc + 1;
      if (game_over_o !== pgo) begin
        if (go_q.size() == 0) check("game_over_unexpected", game_over_o, pgo);
        else check("game_over_cycle", cyc, go_q.pop_front());
      end
      pgo = game_over_o;
    end
  end

  initial begin : driver
    int n;
    reset_n_i = 1'b0; start_i = 1'b1; usr_v_i = 1'b1; usr_opcode_i = eMoveLeft;
    ready_i = 1'b1; done_i = 1'b1; landed_i = 1'b0; lose_i = 1'b0;
    line_elimination_i = 3'd1; line_elimination_v_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_opcode", opcode_o, eNop);
    check("rst_opcode_v", opcode_v_o, 0);
    check("rst_yumi", yumi_o, 0);
    check("rst_usr_yumi", usr_yumi_o, 0);
    check("rst_game_over", game_over_o, 0);
    check("rst_level", level_o, 0);
    start_i = 1'b0; usr_v_i = 1'b0; done_i = 1'b0; ready_i = 1'b0; line_elimination_v_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;

    repeat (4000) cycle_step(1'b1);

    // Reset in the middle of a plate handshake
    n = 0;
    while (!(m_run && ph == PH_WAIT) && n < 300) begin
      cycle_step(1'b1);
      n++;
    end
    check("reach_wait_before_reset", int'(m_run && ph == PH_WAIT), 1);
    #1;
    reset_n_i = 1'b0;
    start_i = 1'b0; done_i = 1'b0; usr_v_i = 1'b0; line_elimination_v_i = 1'b0;
    m_run = 0; m_over = 0; ph = PH_SEL; mq.delete(); pend = 0; consumed = 0;
    #1;
    check("async_rst_opcode", opcode_o, eNop);
    check("async_rst_opcode_v", opcode_v_o, 0);
    check("async_rst_yumi", yumi_o, 0);
    check("async_rst_level", level_o, 0);
    #1;
    reset_n_i = 1'b1;
    repeat (12) cycle_step(1'b0);
    @(negedge clk_i);
    @(negedge clk_i);

    check("op_q_drained", op_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    check("usr_q_drained", uy_q.size(), 0);
    check("game_over_q_drained", go_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
